// File: rtl/fp16_pkg.sv
// Shared half-precision (1/5/10) definitions used by the adder and normalizer.
// Holds field widths, special encodings, FSM states and result classes.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] POS_INF  = 16'h7C00;
    localparam logic [15:0] POS_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_SUB    = 2'd1,
        CLS_ZERO   = 2'd2,
        CLS_INF    = 2'd3
    } cls_t;

    function automatic logic [15:0] pack_word(
        input logic              sign,
        input logic [EXP_W-1:0]  exp_f,
        input logic [FRAC_W-1:0] frac_f
    );
        return {sign, exp_f, frac_f};
    endfunction

endpackage

// File: rtl/fp16_pack.sv
// Combinational packer: turns a normalized sign/exponent/fraction and its
// result class into the binary16 word plus mutually exclusive flags.
module fp16_pack
    import fp16_pkg::*;
(
    input  logic              i_sign,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [FRAC_W-1:0] i_frac,
    input  cls_t              i_cls,
    output logic [15:0]       o_result,
    output logic              o_ovf,
    output logic              o_zero,
    output logic              o_sub
);

    // Select the encoding for each result class.
    always_comb begin
        o_result = POS_ZERO;
        o_ovf    = 1'b0;
        o_zero   = 1'b0;
        o_sub    = 1'b0;
        case (i_cls)
            CLS_NORMAL: o_result = pack_word(i_sign, i_exp, i_frac);
            CLS_SUB: begin
                o_result = pack_word(i_sign, 5'd0, i_frac);
                o_sub    = 1'b1;
            end
            CLS_ZERO: begin
                o_result = POS_ZERO;
                o_zero   = 1'b1;
            end
            CLS_INF: begin
                o_result = POS_INF | {i_sign, 15'h0000};
                o_ovf    = 1'b1;
            end
            default: o_result = POS_ZERO;
        endcase
    end

endmodule

// File: rtl/fp16_normalizer.sv
// Post-add normalization stage: iteratively shifts the adder's raw mantissa
// into place and hands a packed binary16 result over a valid/ready handshake.
module fp16_normalizer
    import fp16_pkg::*;
#(
    parameter int MAX_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [5:0]  in_exp,
    input  logic [11:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_ovf,
    output logic        out_zero,
    output logic        out_sub
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sign,  w_sign_nxt;
    logic [5:0]         r_exp,   w_exp_nxt;
    logic [11:0]        r_mant,  w_mant_nxt;
    cls_t               r_cls,   w_cls_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               w_load_out;
    logic [5:0]         w_exp_inc;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [15:0]        r_out_result;
    logic               r_out_ovf;
    logic               r_out_zero;
    logic               r_out_sub;

    logic [15:0]        w_pk_result;
    logic               w_pk_ovf;
    logic               w_pk_zero;
    logic               w_pk_sub;

    assign w_exp_inc = r_exp + 6'd1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath-next logic; one normalization action per cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_exp_nxt   = r_exp;
        w_mant_nxt  = r_mant;
        w_cls_nxt   = r_cls;
        w_cnt_nxt   = r_cnt;
        w_load_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_sign_nxt  = in_sign;
                    w_exp_nxt   = (in_exp == 6'd0) ? 6'd1 : in_exp;
                    w_mant_nxt  = in_mant;
                    w_cls_nxt   = CLS_NORMAL;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = NORM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            NORM: begin
                if (r_mant == 12'h000) begin
                    w_sign_nxt  = 1'b0;
                    w_cls_nxt   = CLS_ZERO;
                    w_state_nxt = DONE;
                end else if (r_exp >= 6'd31) begin
                    w_cls_nxt   = CLS_INF;
                    w_state_nxt = DONE;
                end else if (r_mant[11]) begin
                    // Truncating right shift absorbs the adder carry.
                    w_mant_nxt  = {1'b0, r_mant[11:1]};
                    w_exp_nxt   = w_exp_inc;
                    w_cls_nxt   = (w_exp_inc >= 6'd31) ? CLS_INF : CLS_NORMAL;
                    w_state_nxt = DONE;
                end else if (r_mant[10]) begin
                    w_cls_nxt   = CLS_NORMAL;
                    w_state_nxt = DONE;
                end else if (r_exp == 6'd1) begin
                    w_cls_nxt   = CLS_SUB;
                    w_state_nxt = DONE;
                end else if (r_cnt == CNT_W'(MAX_SHIFT)) begin
                    // Unreachable for legal operands; bounds the loop regardless.
                    w_cls_nxt   = CLS_SUB;
                    w_state_nxt = DONE;
                end else begin
                    w_mant_nxt  = {r_mant[10:0], 1'b0};
                    w_exp_nxt   = r_exp - 6'd1;
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_nxt = NORM;
                end
            end
            DONE: begin
                if (!r_out_valid) begin
                    w_load_out  = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand / working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
            r_exp  <= 6'd0;
            r_mant <= 12'h000;
            r_cls  <= CLS_NORMAL;
            r_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_sign <= w_sign_nxt;
            r_exp  <= w_exp_nxt;
            r_mant <= w_mant_nxt;
            r_cls  <= w_cls_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    fp16_pack u_pack (
        .i_sign   (r_sign),
        .i_exp    (r_exp[4:0]),
        .i_frac   (r_mant[9:0]),
        .i_cls    (r_cls),
        .o_result (w_pk_result),
        .o_ovf    (w_pk_ovf),
        .o_zero   (w_pk_zero),
        .o_sub    (w_pk_sub)
    );

    // Handshake and held output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= 16'h0000;
            r_out_ovf    <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_sub    <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == IDLE);
            if (w_load_out) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_pk_result;
                r_out_ovf    <= w_pk_ovf;
                r_out_zero   <= w_pk_zero;
                r_out_sub    <= w_pk_sub;
            end else if (r_state == DONE && r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end else begin
                r_out_valid  <= r_out_valid;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_ovf    = r_out_ovf;
    assign out_zero   = r_out_zero;
    assign out_sub    = r_out_sub;

endmodule
